// File: rtl/n2t_pkg.sv
// Shared definitions for the nand2tetris-style datapath blocks.
// Holds the Hack word width and the bit_deserializer state encoding.
package n2t_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PARITY  = 2'd1,
        FULL    = 2'd2
    } deser_state_t;

endpackage

// File: rtl/bit_deserializer_shift_in_reg.sv
// Serial-in/parallel-out shift register with synchronous clear.
// o_shifted is the value the register takes on the next enabled edge.
module shift_in_reg #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_data,
    output logic [WIDTH-1:0] o_shifted
);

    logic [WIDTH-1:0] r_data;

    // MSB-first shifts left so the first bit ends in the top position.
    generate
        if (MSB_FIRST) begin : g_msb
            assign o_shifted = {r_data[WIDTH-2:0], i_bit};
        end else begin : g_lsb
            assign o_shifted = {i_bit, r_data[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_data <= '0;
        end else if (i_en) begin
            r_data <= o_shifted;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/bit_deserializer.sv
// Serial-to-parallel receiver with valid/ready on both sides and a one-word output slot.
// Define BIT_DESER_PARITY_EN to expect an even-parity bit after every word and flag errors on out_err.
module bit_deserializer
    import n2t_pkg::*;
#(
    parameter int WIDTH     = WORD_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    deser_state_t     r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    logic             r_out_err;
    logic             r_err_pend;

    logic             w_clr;
    logic             w_accept;
    logic             w_pop;
    logic             w_slot_free;
    logic             w_last;
    logic             w_shift_en;
    logic [WIDTH-1:0] w_shift_q;
    logic [WIDTH-1:0] w_shifted;
    logic             w_complete;
    logic [WIDTH-1:0] w_word;
    logic             w_word_err;

    assign w_clr       = ~rst_n;
    assign w_accept    = in_valid & r_in_ready;
    assign w_pop       = r_out_valid & out_ready;
    assign w_slot_free = ~r_out_valid | out_ready;
    assign w_last      = (r_count == LAST_CNT);
    assign w_shift_en  = w_accept & (r_state == COLLECT);

    shift_in_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .i_clr     (w_clr),
        .i_en      (w_shift_en),
        .i_bit     (in),
        .o_data    (w_shift_q),
        .o_shifted (w_shifted)
    );

    // A word completing in COLLECT is taken from the shifter's next value so it
    // can reach the output register on the same edge as its last bit.
    always_comb begin
        w_complete = 1'b0;
        w_word     = w_shift_q;
        w_word_err = 1'b0;
        case (r_state)
            COLLECT: begin
                w_word = w_shifted;
`ifndef BIT_DESER_PARITY_EN
                w_complete = w_accept & w_last;
`endif
            end
`ifdef BIT_DESER_PARITY_EN
            PARITY: begin
                w_complete = w_accept;
                w_word_err = (^w_shift_q) ^ in;
            end
`endif
            FULL: begin
                w_complete = 1'b1;
                w_word_err = r_err_pend;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= COLLECT;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_err_pend  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_out_valid <= 1'b0;
            end
            if (w_complete) begin
                r_count <= '0;
                if (w_slot_free) begin
                    r_out       <= w_word;
                    r_out_valid <= 1'b1;
                    r_out_err   <= w_word_err;
                    r_state     <= COLLECT;
                    r_in_ready  <= 1'b1;
                end else begin
                    r_state     <= FULL;
                    r_in_ready  <= 1'b0;
                    r_err_pend  <= w_word_err;
                end
            end else if (w_shift_en) begin
`ifdef BIT_DESER_PARITY_EN
                if (w_last) begin
                    r_count <= '0;
                    r_state <= PARITY;
                end else begin
                    r_count <= r_count + 1'b1;
                end
`else
                r_count <= r_count + 1'b1;
`endif
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign out_err   = r_out_err;

endmodule
